dmem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer for the single-port byte-wide data memory (datamemory).

---
 rtl/dmem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port sequencer for a single-port, byte-wide
// synchronous data memory. Each transaction occupies the memory for exactly
// one cycle (ACCESS) and returns a one-cycle response pulse (RESP), giving a
// fixed IDLE -> ACCESS -> RESP occupancy of three cycles.
module dmem_arbiter #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  // port 0 (CPU load/store)
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic           req0_we,
  input  logic [N-1:0]   req0_addr,
  input  logic [N/2-1:0] req0_wdata,
  output logic           rsp0_valid,
  output logic [N/2-1:0] rsp0_rdata,
  // port 1 (DMA/loader)
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic           req1_we,
  input  logic [N-1:0]   req1_addr,
  input  logic [N/2-1:0] req1_wdata,
  output logic           rsp1_valid,
  output logic [N/2-1:0] rsp1_rdata,
  // memory side
  output logic           mem_write_en,
  output logic [N-1:0]   mem_addr,
  output logic [N-1:0]   mem_datain,
  input  logic [N/2-1:0] mem_dataout,
  output logic           busy
);

  localparam int D = N / 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t         state_reg;
  state_t         state_next;

  // Latched transaction, captured only at accept so later input changes
  // cannot disturb an access already in flight.
  logic           we_reg;
  logic [N-1:0]   addr_reg;
  logic [D-1:0]   wdata_reg;
  logic           owner_reg;
  logic           last_grant_reg;

  // Per-port views of the request/response signals so the two ports can be
  // handled by one generate loop.
  logic [1:0]     valid_vec;
  logic [1:0]     we_vec;
  logic [N-1:0]   addr_vec  [2];
  logic [D-1:0]   wdata_vec [2];
  logic [1:0]     ready_vec;
  logic [1:0]     rsp_valid_vec;
  logic [D-1:0]   rdata_reg [2];
  logic [D-1:0]   rdata_out [2];

  logic           grant;
  logic           idle;
  logic           accept;
  logic [D-1:0]   resp_data;

  assign valid_vec    = {req1_valid, req0_valid};
  assign we_vec       = {req1_we, req0_we};
  assign addr_vec[0]  = req0_addr;
  assign addr_vec[1]  = req1_addr;
  assign wdata_vec[0] = req0_wdata;
  assign wdata_vec[1] = req1_wdata;

  assign idle = (state_reg == IDLE);

  // Round-robin pick: under contention the port that did not win last time
  // gets the grant; a lone requester always wins. last_grant resets to 1 so
  // the first contention after reset goes to port 0.
  always_comb begin
    grant = 1'b0;
    if (valid_vec[0] && valid_vec[1]) begin
      grant = ~last_grant_reg;
    end else if (valid_vec[1]) begin
      grant = 1'b1;
    end
  end

  // ready is only ever offered in IDLE and never while reset is held.
  assign accept = idle && !rst && (valid_vec != 2'b00);

  // Next-state logic for the fixed three-cycle transaction sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (valid_vec != 2'b00) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; asynchronous reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the granted request and remember who won for round-robin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else if (accept) begin
      we_reg         <= we_vec[grant];
      addr_reg       <= addr_vec[grant];
      wdata_reg      <= wdata_vec[grant];
      owner_reg      <= grant;
      last_grant_reg <= grant;
    end
  end

  // Memory drive: address/data simply hold the latched request; the write
  // strobe is decoded from state so it falls the instant reset is asserted.
  assign mem_write_en = (state_reg == ACCESS) && we_reg;
  assign mem_addr     = addr_reg;
  assign mem_datain   = {{(N - D){1'b0}}, wdata_reg};

  // The memory's registered output is valid during RESP; writes ack with 0.
  assign resp_data = we_reg ? '0 : mem_dataout;

  assign busy = !idle;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign ready_vec[gi]     = accept && (grant == 1'(gi));
      assign rsp_valid_vec[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));

      // Hold the last response byte for this port until its next response.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_reg[gi] <= '0;
        end else if (rsp_valid_vec[gi]) begin
          rdata_reg[gi] <= resp_data;
        end
      end

      // During the response cycle the fresh byte is forwarded straight from
      // the memory's output register; otherwise the held copy is shown.
      assign rdata_out[gi] = rsp_valid_vec[gi] ? resp_data : rdata_reg[gi];
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign rsp0_valid = rsp_valid_vec[0];
  assign rsp1_valid = rsp_valid_vec[1];
  assign rsp0_rdata = rdata_out[0];
  assign rsp1_rdata = rdata_out[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus for dmem_arbiter with a byte-wide
// synchronous memory model. Expected responses and memory writes are queued
// when requests are accepted; a negedge monitor pops and compares them.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [15:0] req0_addr  = '0;
  logic [7:0]  req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [15:0] req1_addr  = '0;
  logic [7:0]  req1_wdata = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [7:0]  rsp0_rdata, rsp1_rdata;
  logic        mem_write_en, busy;
  logic [15:0] mem_addr, mem_datain;
  logic [7:0]  mem_dataout = '0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] rdata;
    int         cyc;
    string      name;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wexp_t;

  exp_t  q0[$];
  exp_t  q1[$];
  wexp_t wq[$];

  dmem_arbiter #(.N(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_datain(mem_datain),
    .mem_dataout(mem_dataout), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: unwritten bytes read as (addr[7:0] ^ 0x5A), read-first.
  bit [7:0] mem_model   [0:65535];
  bit       mem_written [0:65535];
  always @(posedge clk) begin
    if (mem_write_en) begin
      mem_model[mem_addr]   <= mem_datain[7:0];
      mem_written[mem_addr] <= 1'b1;
    end
    mem_dataout <= mem_written[mem_addr] ? mem_model[mem_addr] : (mem_addr[7:0] ^ 8'h5A);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Response and write monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp0_valid) begin
        chk("rsp0_expected", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) begin
          exp_t e;
          e = q0.pop_front();
          $display("rsp port0 %s rdata=0x%02h cyc=%0d", e.name, rsp0_rdata, cyc);
          chk({e.name, "_rdata"}, 32'(rsp0_rdata), 32'(e.rdata));
          chk({e.name, "_latency"}, cyc, e.cyc);
        end
      end
      if (rsp1_valid) begin
        chk("rsp1_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          exp_t e;
          e = q1.pop_front();
          $display("rsp port1 %s rdata=0x%02h cyc=%0d", e.name, rsp1_rdata, cyc);
          chk({e.name, "_rdata"}, 32'(rsp1_rdata), 32'(e.rdata));
          chk({e.name, "_latency"}, cyc, e.cyc);
        end
      end
      if (mem_write_en) begin
        chk("write_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          wexp_t w;
          w = wq.pop_front();
          chk("write_addr", 32'(mem_addr), 32'(w.addr));
          chk("write_data", 32'(mem_datain), {24'd0, w.data});
        end
      end
    end
  end

  task automatic set_port(input int port, input logic v, input logic we,
                          input logic [15:0] addr, input logic [7:0] wdata);
    if (port == 0) begin
      req0_valid = v; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end
  endtask

  // Present a request and wait (bounded) for it to be accepted.
  task automatic wait_accept(input int port, input string name, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((port == 0) ? req0_ready : req1_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_accept"}, 32'(got), 32'd1);
  endtask

  // Full transaction: expected response/write queued at accept; request
  // address optionally changed right after accept to prove it is ignored.
  task automatic do_req(input int port, input logic we, input logic [15:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rdata,
                        input logic [15:0] post_addr, input string name);
    bit   got;
    exp_t e;
    @(negedge clk);
    set_port(port, 1'b1, we, addr, wdata);
    wait_accept(port, name, got);
    if (got) begin
      e.rdata = exp_rdata;
      e.cyc   = cyc + 2;
      e.name  = name;
      if (port == 0) q0.push_back(e); else q1.push_back(e);
      if (we) wq.push_back('{addr, wdata});
      @(posedge clk);
      #1;
      set_port(port, 1'b1, we, post_addr, wdata ^ 8'hFF);
      @(posedge clk);
      #1;
    end
    set_port(port, 1'b0, 1'b0, post_addr, 8'h00);
  endtask

  // Request that will be killed by reset during ACCESS: no expectation queued.
  task automatic accept_only(input int port, input logic we, input logic [15:0] addr,
                             input logic [7:0] wdata, input string name);
    bit got;
    @(negedge clk);
    set_port(port, 1'b1, we, addr, wdata);
    wait_accept(port, name, got);
    if (got) @(posedge clk);
    #1;
    set_port(port, 1'b0, 1'b0, addr, wdata);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req0_ready"},   32'(req0_ready),   32'd0);
    chk({tag, "_req1_ready"},   32'(req1_ready),   32'd0);
    chk({tag, "_rsp0_valid"},   32'(rsp0_valid),   32'd0);
    chk({tag, "_rsp1_valid"},   32'(rsp1_valid),   32'd0);
    chk({tag, "_rsp0_rdata"},   32'(rsp0_rdata),   32'd0);
    chk({tag, "_rsp1_rdata"},   32'(rsp1_rdata),   32'd0);
    chk({tag, "_mem_write_en"}, 32'(mem_write_en), 32'd0);
    chk({tag, "_mem_addr"},     32'(mem_addr),     32'd0);
    chk({tag, "_mem_datain"},   32'(mem_datain),   32'd0);
    chk({tag, "_busy"},         32'(busy),         32'd0);
  endtask

  initial begin
    int order [4];
    int prev_acc;
    bit got;
    order = '{0, 1, 0, 1};

    // Power-on reset.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;

    // Port 0 write 0x1234 <= 0xA5, then read it back.
    do_req(0, 1'b1, 16'h1234, 8'hA5, 8'h00, 16'h1234, "p0_wr_1234");
    do_req(0, 1'b0, 16'h1234, 8'h00, 8'hA5, 16'h1234, "p0_rd_1234");
    repeat (3) @(posedge clk);
    #1;
    chk("held_rsp0_rdata", 32'(rsp0_rdata), 32'h0000_00A5);

    // Reset mid-run: port 0 read killed in ACCESS (last_grant was port 0).
    accept_only(0, 1'b0, 16'h1234, 8'h00, "p0_rd_killed");
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Contention: both ports hold valid; grants must go 0,1,0,1.
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 16'h0000, 8'h00);
    set_port(1, 1'b1, 1'b0, 16'hFFFF, 8'h00);
    prev_acc = 0;
    for (int k = 0; k < 4; k++) begin
      int   p;
      exp_t e;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (req0_ready || req1_ready) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("contend_accept", 32'(got), 32'd1);
      if (!got) break;
      p = req1_ready ? 1 : 0;
      chk($sformatf("contend_grant%0d", k), p, order[k]);
      e.rdata = (p == 1) ? 8'hA5 : 8'h5A;
      e.cyc   = cyc + 2;
      e.name  = $sformatf("contend%0d_p%0d", k, p);
      if (p == 0) q0.push_back(e); else q1.push_back(e);
      if (k > 0) chk($sformatf("contend_spacing%0d", k), cyc - prev_acc, 3);
      prev_acc = cyc;
      @(posedge clk);
    end
    #1;
    set_port(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    set_port(1, 1'b0, 1'b0, 16'h0000, 8'h00);

    // Port 1 alone at the top address.
    do_req(1, 1'b1, 16'hFFFF, 8'h3C, 8'h00, 16'hFFFF, "p1_wr_ffff");
    do_req(1, 1'b0, 16'hFFFF, 8'h00, 8'h3C, 16'hFFFF, "p1_rd_ffff");

    // Address changed after accept: memory must still see 0x0010.
    do_req(0, 1'b0, 16'h0010, 8'h00, 8'h4A, 16'h0020, "p0_rd_0010_chg");

    // Reset during ACCESS of a write to 0x0050: strobe drops at once.
    accept_only(0, 1'b1, 16'h0050, 8'h77, "p0_wr_0050_killed");
    chk("killed_wr_strobe_high", 32'(mem_write_en), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("killed_wr_strobe_low", 32'(mem_write_en), 32'd0);
    chk("killed_wr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_req(0, 1'b0, 16'h0050, 8'h00, 8'h0A, 16'h0050, "p0_rd_0050");

    // Drain, bounded.
    for (int i = 0; i < 50; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && wq.size() == 0) break;
      @(posedge clk);
    end
    repeat (4) @(posedge clk);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    chk("drain_wq", wq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
